// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Each accepted operation goes through IDLE -> EXEC -> RESP, and the
// result is held until the owning requester consumes it.
module alu_share_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [3:0]  req0_ctrl,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,
   output logic        rsp0_zero,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [3:0]  req1_ctrl,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,
   output logic        rsp1_zero,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_ctrl,
   input  logic [31:0] alu_result,
   input  logic        alu_zero
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state;
   state_t      state_next;
   logic        ptr;
   logic        owner;
   logic        grant_any;
   logic        grant_id;
   logic        handshake;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  op_ctrl;
   logic [31:0] res;
   logic        res_zero;

   // Next-state, grant selection and handshake outputs.
   always_comb begin
      state_next = state;
      grant_any  = 1'b0;
      grant_id   = ptr;
      handshake  = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      case (state)
         IDLE: begin
            // ptr only breaks ties; a lone requester always wins.
            if (!rst && (req0_valid || req1_valid)) begin
               grant_any  = 1'b1;
               grant_id   = (req0_valid && req1_valid) ? ptr : req1_valid;
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               state_next = EXEC;
            end
         end
         EXEC: state_next = RESP;
         RESP: begin
            rsp0_valid = ~owner;
            rsp1_valid = owner;
            handshake  = owner ? rsp1_ready : rsp0_ready;
            if (handshake) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State, ownership, priority pointer, operand and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= 1'b0;
         owner    <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_ctrl  <= '0;
         res      <= '0;
         res_zero <= 1'b0;
      end else begin
         state <= state_next;
         if (grant_any) begin
            owner   <= grant_id;
            op_a    <= grant_id ? req1_a    : req0_a;
            op_b    <= grant_id ? req1_b    : req0_b;
            op_ctrl <= grant_id ? req1_ctrl : req0_ctrl;
         end
         if (state == EXEC) begin
            res      <= alu_result;
            res_zero <= alu_zero;
         end
         if (handshake) ptr <= ~owner;
      end
   end

   assign alu_a       = op_a;
   assign alu_b       = op_b;
   assign alu_ctrl    = op_ctrl;
   assign rsp0_result = res;
   assign rsp0_zero   = res_zero;
   assign rsp1_result = res;
   assign rsp1_zero   = res_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural shared ALU.
module tb_alu_share_arbiter;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
   logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
   logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
   logic [3:0]  req0_ctrl, req1_ctrl, alu_ctrl;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        alu_zero;

   int checks   = 0;
   int failures = 0;
   logic [32:0] q0[$];
   logic [32:0] q1[$];
   int          glog[$];
   int          w0, w1;

   always #5 clk = ~clk;

   alu_share_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
      .req0_b(req0_b), .req0_ctrl(req0_ctrl), .rsp0_valid(rsp0_valid),
      .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
      .req1_b(req1_b), .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid),
      .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   // Reference ALU: {zero, result}; undefined codes give 0.
   function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
      logic [31:0] r;
      r = '0;
      case (c)
         4'd0: r = a + b;
         4'd1: r = a - b;
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = a << b[4:0];
         4'd6: r = a >> b[4:0];
         4'd7: r = $signed(a) >>> b[4:0];
         4'd8: r = {31'b0, ($signed(a) < $signed(b))};
         4'd9: r = {31'b0, (a < b)};
         default: r = '0;
      endcase
      return {(r == 32'd0), r};
   endfunction

   // Shared ALU seen by the DUT.
   always_comb {alu_zero, alu_result} = alu_ref(alu_a, alu_b, alu_ctrl);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Raise a request at posedge+1, wait for its grant, push the expected result.
   task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, output int waited);
      bit got;
      got = 0;
      waited = -1;
      if (id == 0) begin
         req0_a = a; req0_b = b; req0_ctrl = c; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_ctrl = c; req1_valid = 1'b1;
      end
      for (int n = 0; n < 60 && !got; n++) begin
         @(negedge clk);
         if ((id == 0) ? req0_ready : req1_ready) begin
            got = 1;
            waited = n;
         end
      end
      check("grant", 32'(got), 32'd1);
      if (got) begin
         if (id == 0) q0.push_back(alu_ref(a, b, c));
         else         q1.push_back(alu_ref(a, b, c));
      end
      @(posedge clk); #1;
      if (id == 0) req0_valid = 1'b0;
      else         req1_valid = 1'b0;
   endtask

   // Wait until the scoreboard queue for a requester drains, then realign.
   task automatic wait_rsp(input int id);
      for (int n = 0; n < 60; n++) begin
         if (((id == 0) ? q0.size() : q1.size()) == 0) break;
         @(negedge clk);
      end
      check("rsp_drain", 32'((id == 0) ? q0.size() : q1.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   // Protocol monitor and scoreboard pop on response handshakes.
   always @(negedge clk) begin
      if (rst) begin
         check("rdy_in_rst", {30'b0, req1_ready, req0_ready}, 32'd0);
      end else begin
         if (req0_ready || req1_ready)
            check("rdy_excl", 32'(req0_ready & req1_ready), 32'd0);
         if (rsp0_valid || rsp1_valid)
            check("rsp_excl", 32'(rsp0_valid & rsp1_valid), 32'd0);
         if (req0_ready) glog.push_back(0);
         if (req1_ready) glog.push_back(1);
         if (rsp0_valid && rsp0_ready) begin
            if (q0.size() == 0) check("rsp0_unexp", 32'(q0.size()), 32'd1);
            else begin
               logic [32:0] e;
               e = q0.pop_front();
               check("rsp0_result", rsp0_result, e[31:0]);
               check("rsp0_zero", 32'(rsp0_zero), 32'(e[32]));
            end
         end
         if (rsp1_valid && rsp1_ready) begin
            if (q1.size() == 0) check("rsp1_unexp", 32'(q1.size()), 32'd1);
            else begin
               logic [32:0] e;
               e = q1.pop_front();
               check("rsp1_result", rsp1_result, e[31:0]);
               check("rsp1_zero", 32'(rsp1_zero), 32'(e[32]));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0; rsp0_ready = 1'b1;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0; rsp1_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);
      check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
      check("rst_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
      check("rst_result", rsp0_result, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // ADD 5+7 with latency check
      issue(0, 32'd5, 32'd7, OP_ADD, w0);
      check("add_grant_lat", 32'(w0), 32'd0);
      check("add_exec_v", 32'(rsp0_valid), 32'd0);
      @(posedge clk); #1;
      check("add_resp_v", 32'(rsp0_valid), 32'd1);
      check("add_resp_res", rsp0_result, 32'd12);
      check("add_resp_zero", 32'(rsp0_zero), 32'd0);
      wait_rsp(0);

      // SUB 9-9 -> zero
      issue(0, 32'd9, 32'd9, OP_SUB, w0);
      wait_rsp(0);

      // Both requesters continuously valid after reset: grants 0,1,0,1
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      glog.delete();
      fork
         begin
            issue(0, 32'h0000_00F0, 32'h0000_000F, OP_OR, w0);
            issue(0, 32'h0000_00F0, 32'h0000_000F, OP_OR, w0);
         end
         begin
            issue(1, 32'd1, 32'd4, OP_SLL, w1);
            issue(1, 32'd1, 32'd4, OP_SLL, w1);
         end
      join
      wait_rsp(0);
      wait_rsp(1);
      check("rr_count", 32'(glog.size()), 32'd4);
      for (int i = 0; i < 4 && i < glog.size(); i++)
         check($sformatf("rr_order%0d", i), 32'(glog[i]), 32'(i % 2));

      // Backpressure on rsp0 while req1 waits
      rsp0_ready = 1'b0;
      issue(0, 32'd3, 32'd4, OP_ADD, w0);
      req1_a = 32'd10; req1_b = 32'd3; req1_ctrl = OP_SUB; req1_valid = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("hold_v", 32'(rsp0_valid), 32'd1);
         check("hold_res", rsp0_result, 32'd7);
         check("hold_r1rdy", 32'(req1_ready), 32'd0);
         @(posedge clk); #1;
      end
      rsp0_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("r1_after_hs", 32'(req1_ready), 32'd1);
      if (req1_ready) q1.push_back(alu_ref(32'd10, 32'd3, OP_SUB));
      @(posedge clk); #1;
      req1_valid = 1'b0;
      wait_rsp(1);

      // Reset during EXEC of req1 SRA discards the operation
      req1_a = 32'h8000_0000; req1_b = 32'd4; req1_ctrl = OP_SRA; req1_valid = 1'b1;
      @(negedge clk);
      check("sra_rdy", 32'(req1_ready), 32'd1);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("abort_v", 32'(rsp1_valid), 32'd0);
         check("abort_res", rsp1_result, 32'd0);
         check("abort_alu_a", alu_a, 32'd0);
         check("abort_alu_ctrl", 32'(alu_ctrl), 32'd0);
      end
      @(posedge clk); #1;
      issue(0, 32'hA5A5_A5A5, 32'h0F0F_0F0F, OP_XOR, w0);
      check("post_rst_lat", 32'(w0), 32'd0);
      wait_rsp(0);

      // Signed vs unsigned compare
      issue(1, 32'hFFFF_FFFF, 32'd1, OP_SLT, w1);
      wait_rsp(1);
      issue(1, 32'hFFFF_FFFF, 32'd1, OP_SLTU, w1);
      wait_rsp(1);

      // Undefined code forwarded unchanged
      issue(0, 32'd3, 32'd4, 4'hC, w0);
      check("undef_ctrl_fwd", 32'(alu_ctrl), 32'hC);
      wait_rsp(0);

      check("q0_empty", 32'(q0.size()), 32'd0);
      check("q1_empty", 32'(q1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
